// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: opcodes, result record and legality check shared by the ALU result path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_OP_LEN = 5;

  localparam logic [ALU_OP_LEN-1:0] ALU_OP_ADD_U = 5'b00001;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_NEG   = 5'b00010;

  typedef struct packed {
    logic [ALU_OP_LEN-1:0] opcode;
    logic [ALU_WIDTH-1:0]  sum;
    logic                  cout;
    logic                  neg;
    logic                  ovf;
    logic                  zero;
  } alu_result_t;

  function automatic logic alu_op_legal(input logic [ALU_OP_LEN-1:0] op);
    return (op == ALU_OP_ADD_U) || (op == ALU_OP_NEG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if: ALU-result input and consumer output handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_result_stage_if #(
  parameter int WIDTH  = 32,
  parameter int OP_LEN = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_LEN-1:0] in_opcode;
  logic [WIDTH-1:0]  in_sum;
  logic              in_cout;
  logic              in_neg;
  logic              in_ovf;
  logic              in_zero;

  logic              out_valid;
  logic              out_ready;
  logic [OP_LEN-1:0] out_opcode;
  logic [WIDTH-1:0]  out_sum;
  logic              out_cout;
  logic              out_neg;
  logic              out_ovf;
  logic              out_zero;

  // master: ALU producer plus consumer side; slave: the result stage itself
  modport master (
    output in_valid, in_opcode, in_sum, in_cout, in_neg, in_ovf, in_zero, out_ready,
    input  in_ready, out_valid, out_opcode, out_sum, out_cout, out_neg, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_opcode, in_sum, in_cout, in_neg, in_ovf, in_zero, out_ready,
    output in_ready, out_valid, out_opcode, out_sum, out_cout, out_neg, out_ovf, out_zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_res_fifo2.sv
// ---------------------------------------------------------------------------
// alu_res_fifo2: 2-entry registered FIFO of alu_result_t, head always on data_o
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_res_fifo2
  import alu_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        push_i,
  input  wire logic        pop_i,
  input  wire alu_result_t data_i,
  output alu_result_t      data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0]  count_q, count_d;
  alu_result_t head_q, head_d;
  alu_result_t tail_q, tail_d;
  logic        w_pop;
  logic        w_push;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = head_q;
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & ~full_o;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (w_pop) begin
      if (count_q == 2'd2) head_d = tail_q;
      count_d = count_q - 2'd1;
    end
    // new entry lands behind whatever survives this cycle's pop
    if (w_push) begin
      if (count_d == 2'd0) head_d = data_i;
      else                 tail_d = data_i;
      count_d = count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage: buffered ALU result stage with op/illegal counters.
// Optional sticky ovf/cout flags when ALU_STICKY_FLAGS_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int OP_LEN = ALU_OP_LEN,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  alu_result_stage_if.slave     bus,
  output logic [CNT_W-1:0]      op_count,
  output logic [CNT_W-1:0]      illegal_count,
  input  wire logic             sticky_clr,
  output logic                  sticky_ovf,
  output logic                  sticky_cout
);

  alu_result_t      w_in;
  alu_result_t      w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_legal;
  logic             w_pop;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [CNT_W-1:0] ill_count_q, ill_count_d;

  assign w_in.opcode = bus.in_opcode[OP_LEN-1:0];
  assign w_in.sum    = bus.in_sum[WIDTH-1:0];
  assign w_in.cout   = bus.in_cout;
  assign w_in.neg    = bus.in_neg;
  assign w_in.ovf    = bus.in_ovf;
  assign w_in.zero   = bus.in_zero;

  // in_ready depends only on registered occupancy
  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign w_accept      = bus.in_valid & ~w_full;
  assign w_legal       = alu_op_legal(w_in.opcode);
  assign w_pop         = ~w_empty & bus.out_ready;

  alu_res_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_accept & w_legal),
    .pop_i   (w_pop),
    .data_i  (w_in),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign bus.out_opcode = w_head.opcode[OP_LEN-1:0];
  assign bus.out_sum    = w_head.sum[WIDTH-1:0];
  assign bus.out_cout   = w_head.cout;
  assign bus.out_neg    = w_head.neg;
  assign bus.out_ovf    = w_head.ovf;
  assign bus.out_zero   = w_head.zero;

  always_comb begin
    op_count_d  = op_count_q;
    ill_count_d = ill_count_q;
    if (w_pop && (op_count_q != '1))                   op_count_d  = op_count_q + 1'b1;
    if (w_accept && !w_legal && (ill_count_q != '1))   ill_count_d = ill_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q  <= '0;
      ill_count_q <= '0;
    end else begin
      op_count_q  <= op_count_d;
      ill_count_q <= ill_count_d;
    end
  end

  assign op_count      = op_count_q;
  assign illegal_count = ill_count_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_ovf_q, sticky_ovf_d;
  logic sticky_cout_q, sticky_cout_d;

  // a setting pop outranks a simultaneous clear
  always_comb begin
    sticky_ovf_d  = sticky_ovf_q;
    sticky_cout_d = sticky_cout_q;
    if (sticky_clr) begin
      sticky_ovf_d  = 1'b0;
      sticky_cout_d = 1'b0;
    end
    if (w_pop && w_head.ovf)  sticky_ovf_d  = 1'b1;
    if (w_pop && w_head.cout) sticky_cout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_q  <= 1'b0;
      sticky_cout_q <= 1'b0;
    end else begin
      sticky_ovf_q  <= sticky_ovf_d;
      sticky_cout_q <= sticky_cout_d;
    end
  end

  assign sticky_ovf  = sticky_ovf_q;
  assign sticky_cout = sticky_cout_q;
`else
  logic w_unused_sticky_clr;
  assign w_unused_sticky_clr = sticky_clr;
  assign sticky_ovf          = 1'b0;
  assign sticky_cout         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage: directed scenarios plus random traffic against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_result_stage;

  localparam int W = 32;
  localparam int L = 5;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         sticky_clr;
  logic [C-1:0] op_count;
  logic [C-1:0] illegal_count;
  logic         sticky_ovf;
  logic         sticky_cout;

  alu_result_stage_if #(.WIDTH(W), .OP_LEN(L)) bus ();

  alu_result_stage #(.WIDTH(W), .OP_LEN(L), .CNT_W(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .op_count      (op_count),
    .illegal_count (illegal_count),
    .sticky_clr    (sticky_clr),
    .sticky_ovf    (sticky_ovf),
    .sticky_cout   (sticky_cout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // record = {opcode, sum, cout, neg, ovf, zero}
  typedef logic [L+W+3:0] rec_t;
  rec_t         m_q[$];
  rec_t         m_last;
  int           m_ops;
  int           m_ill;
  bit           m_sovf;
  bit           m_scout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    rec_t shown;
    shown = {bus.out_opcode, bus.out_sum, bus.out_cout, bus.out_neg, bus.out_ovf, bus.out_zero};
    chk("in_ready", 64'(bus.in_ready), 64'(m_q.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("head", 64'(shown), 64'(m_q[0]));
    else                chk("held_data", 64'(shown), 64'(m_last));
    chk("op_count", 64'(op_count), 64'(m_ops));
    chk("illegal_count", 64'(illegal_count), 64'(m_ill));
`ifdef ALU_STICKY_FLAGS_EN
    chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sovf));
    chk("sticky_cout", 64'(sticky_cout), 64'(m_scout));
`else
    chk("sticky_ovf_off", 64'(sticky_ovf), 64'd0);
    chk("sticky_cout_off", 64'(sticky_cout), 64'd0);
`endif
  endtask

  // One cycle: check state left by the previous edge, drive, advance the model.
  task automatic step(input bit r, input bit v, input logic [L-1:0] op, input logic [W-1:0] s,
                      input logic [3:0] fl, input bit ordy, input bit clr);
    bit   can_take;
    bit   legal;
    rec_t head;
    @(negedge clk);
    check_outputs();
    rst           = r;
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_sum    = s;
    {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero} = fl;
    bus.out_ready = ordy;
    sticky_clr    = clr;
    if (r) begin
      m_q.delete();
      m_last  = '0;
      m_ops   = 0;
      m_ill   = 0;
      m_sovf  = 0;
      m_scout = 0;
    end else begin
      can_take = v && (m_q.size() < 2);
      legal    = (op == 5'd1) || (op == 5'd2);
      if (clr) begin
        m_sovf  = 0;
        m_scout = 0;
      end
      if (ordy && m_q.size() > 0) begin
        head   = m_q.pop_front();
        m_last = head;
        if (m_ops < 65535) m_ops++;
        if (head[1]) m_sovf  = 1;
        if (head[3]) m_scout = 1;
      end
      if (can_take && legal) m_q.push_back({op, s, fl});
      if (can_take && !legal && m_ill < 65535) m_ill++;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 4'd0, ordy, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 32'd0, 4'd0, 0, 0);
    step(1, 0, 5'd0, 32'd0, 4'd0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    sticky_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_sum = '0;
    {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero} = 4'd0;
    bus.out_ready = 1'b0;
    m_last = '0; m_ops = 0; m_ill = 0; m_sovf = 0; m_scout = 0;
    @(posedge clk);
    do_reset();

    // single add result flows straight through
    step(0, 1, 5'd1, 32'h0000_0005, 4'd0, 1, 0);
    idle(3, 1);

    // stalled consumer: third push must be held off, then drain in order
    step(0, 1, 5'd1, 32'hA, 4'd0, 0, 0);
    step(0, 1, 5'd2, 32'hB, 4'b0100, 0, 0);
    step(0, 1, 5'd1, 32'hC, 4'd0, 0, 0);
    step(0, 1, 5'd1, 32'hC, 4'd0, 0, 0);
    idle(4, 1);

    // illegal opcode is dropped and counted
    do_reset();
    step(0, 1, 5'b00111, 32'h1234, 4'd0, 1, 0);
    idle(2, 1);

    // fill, then sustained push+pop
    do_reset();
    step(0, 1, 5'd1, 32'h100, 4'd0, 0, 0);
    step(0, 1, 5'd1, 32'h101, 4'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 5'd2, 32'h200 + 32'(i), 4'(i), 1, 0);
    idle(4, 1);

    // sticky: set, set together with clear, clear alone
    step(0, 1, 5'd1, 32'h7, 4'b0010, 0, 0);
    step(0, 0, 5'd0, 32'd0, 4'd0, 1, 0);
    step(0, 1, 5'd1, 32'h8, 4'b1010, 0, 0);
    step(0, 0, 5'd0, 32'd0, 4'd0, 1, 1);
    step(0, 0, 5'd0, 32'd0, 4'd0, 0, 0);
    step(0, 0, 5'd0, 32'd0, 4'd0, 0, 1);
    idle(2, 0);

    // reset with two buffered entries
    step(0, 1, 5'd1, 32'h55, 4'd0, 0, 0);
    step(0, 1, 5'd2, 32'h66, 4'd0, 0, 0);
    step(1, 0, 5'd0, 32'd0, 4'd0, 0, 0);
    idle(2, 1);

    // random traffic with occasional illegal ops, clears and resets
    for (int i = 0; i < 3000; i++) begin
      logic [L-1:0] op;
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : (($urandom & 1) ? 5'd1 : 5'd2);
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 2) != 0, op, $urandom,
           4'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    idle(4, 1);
    @(negedge clk);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
